// File: rtl/ecc_pkg.sv
// ---------------------------------------------------------------------------
// ecc_pkg
// Shared definitions for the ECDSA datapath blocks.
//   SECP256K1_P : the secp256k1 field prime, default modulus
//   op_e        : operation encoding (OP_SUB = 0, OP_ADD = 1)
//   state_e     : control FSM state encoding for mod_addsub_serial
// ---------------------------------------------------------------------------
package ecc_pkg;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic {
        OP_SUB = 1'b0,
        OP_ADD = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/limb_addsub.sv
// ---------------------------------------------------------------------------
// limb_addsub
// One LIMB-bit slice of a ripple add/subtract chain.
//   a, b  : limb operands
//   sub   : 0 = y = a + b + cin, 1 = y = a - b - cin
//   cin   : carry in (add) or borrow in (subtract)
//   y     : limb result
//   cout  : carry out (add) or borrow out (subtract)
// ---------------------------------------------------------------------------
module limb_addsub #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            sub,
    input  logic            cin,
    output logic [LIMB-1:0] y,
    output logic            cout
);

    logic [LIMB:0] sum;

    // One extra bit holds the carry; for subtraction it goes to 1 exactly
    // when the difference is negative, i.e. it is the borrow out.
    always_comb begin
        sum = '0;
        if (sub) begin
            sum = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, cin};
        end else begin
            sum = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};
        end
        y    = sum[LIMB-1:0];
        cout = sum[LIMB];
    end

endmodule

// File: rtl/mod_addsub_serial.sv
// ---------------------------------------------------------------------------
// mod_addsub_serial
// Limb-serial modular adder/subtractor: out_r = (A + B) mod P or
// (A - B) mod P, LIMB bits per clock, LSB limb first.
//
// Parameters:
//   WIDTH   : operand/result width (WIDTH % LIMB must be 0)
//   LIMB    : bits processed per cycle
//   MODULUS : prime modulus, defaults to secp256k1 p
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   in_op               : 0 = subtract, 1 = add
//   in_a, in_b          : operands, expected < MODULUS
//   out_valid/out_ready : result handshake
//   out_r               : result in [0, MODULUS)
//   out_err             : operand range error (only with
//                         MOD_ADDSUB_RANGE_CHK_EN defined)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Operands are captured only on that edge. out_valid stays high
// with out_r stable until out_ready is seen high; the op retires on that
// edge and in_ready rises the following cycle.
//
// Optional feature macro: MOD_ADDSUB_RANGE_CHK_EN adds out_err and a serial
// comparison of A and B against MODULUS.
// ---------------------------------------------------------------------------
module mod_addsub_serial
    import ecc_pkg::*;
#(
    parameter int               WIDTH   = 256,
    parameter int               LIMB    = 64,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(SECP256K1_P)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    ,
    output logic             out_err
`endif
);

    localparam int NLIMB = WIDTH / LIMB;
    localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    // Modulus viewed as an array of limbs, indexed by the limb counter.
    localparam logic [NLIMB-1:0][LIMB-1:0] P_LIMBS = MODULUS;

    if ((WIDTH % LIMB) != 0) begin : g_bad_limb
        $error("mod_addsub_serial: WIDTH must be a multiple of LIMB");
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;
    logic   accept;
    logic   run;
    logic   retire;
    logic   last;

    logic [CW-1:0] cnt_q;

    assign last = (cnt_q == CW'(NLIMB - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        run       = 1'b0;
        retire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [NLIMB-1:0][LIMB-1:0] a_q;
    logic [NLIMB-1:0][LIMB-1:0] b_q;
    logic [NLIMB-1:0][LIMB-1:0] main_q;   // D (sub) or S (add)
    logic [NLIMB-1:0][LIMB-1:0] corr_q;   // T
    logic [NLIMB-1:0][LIMB-1:0] main_full;
    logic [NLIMB-1:0][LIMB-1:0] corr_full;
    op_e                        op_q;
    logic                       c_main_q; // bd (sub) or cs (add)
    logic                       c_corr_q; // T-chain carry (sub) or bt (add)
    logic [WIDTH-1:0]           r_q;
    logic [WIDTH-1:0]           r_sel;

    logic [LIMB-1:0] a_l;
    logic [LIMB-1:0] b_l;
    logic [LIMB-1:0] p_l;
    logic [LIMB-1:0] main_y;
    logic [LIMB-1:0] corr_y;
    logic            main_cout;
    logic            corr_cout;
    logic            use_t;

    assign a_l = a_q[cnt_q];
    assign b_l = b_q[cnt_q];
    assign p_l = P_LIMBS[cnt_q];

    // Main chain: D = A - B or S = A + B.
    limb_addsub #(.LIMB(LIMB)) u_main (
        .a    (a_l),
        .b    (b_l),
        .sub  (op_q == OP_SUB),
        .cin  (c_main_q),
        .y    (main_y),
        .cout (main_cout)
    );

    // Correction chain runs on the main chain's limb in the same cycle:
    // T = D + P for subtract, T = S - P for add.
    limb_addsub #(.LIMB(LIMB)) u_corr (
        .a    (main_y),
        .b    (p_l),
        .sub  (op_q == OP_ADD),
        .cin  (c_corr_q),
        .y    (corr_y),
        .cout (corr_cout)
    );

    // Full-width views including the limb produced this cycle, so the
    // final select can happen on the same edge as the last limb.
    always_comb begin
        main_full        = main_q;
        corr_full        = corr_q;
        main_full[cnt_q] = main_y;
        corr_full[cnt_q] = corr_y;
        use_t            = 1'b0;
        if (op_q == OP_SUB) begin
            // A - B went negative: wrap by adding P.
            use_t = main_cout;
        end else begin
            // A + B overflowed WIDTH, or S >= P (no borrow from S - P).
            use_t = main_cout | ~corr_cout;
        end
        r_sel = use_t ? corr_full : main_full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            main_q   <= '0;
            corr_q   <= '0;
            op_q     <= OP_SUB;
            cnt_q    <= '0;
            c_main_q <= 1'b0;
            c_corr_q <= 1'b0;
            r_q      <= '0;
        end else if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            op_q     <= op_e'(in_op);
            cnt_q    <= '0;
            c_main_q <= 1'b0;
            c_corr_q <= 1'b0;
        end else if (run) begin
            main_q   <= main_full;
            corr_q   <= corr_full;
            c_main_q <= main_cout;
            c_corr_q <= corr_cout;
            if (last) begin
                cnt_q <= '0;
                r_q   <= r_sel;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign out_r = r_q;

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    // ------------------------------------------------------------------
    // Range check: LSB-first magnitude compare of A and B against P.
    // The flag starts at 1 (equal counts as out of range); a higher limb
    // that differs overrides whatever the lower limbs decided.
    // ------------------------------------------------------------------
    logic ge_a_q;
    logic ge_b_q;
    logic ge_a_d;
    logic ge_b_d;
    logic err_q;

    always_comb begin
        ge_a_d = ge_a_q;
        ge_b_d = ge_b_q;
        if (a_l > p_l) begin
            ge_a_d = 1'b1;
        end else if (a_l < p_l) begin
            ge_a_d = 1'b0;
        end
        if (b_l > p_l) begin
            ge_b_d = 1'b1;
        end else if (b_l < p_l) begin
            ge_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ge_a_q <= 1'b0;
            ge_b_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            ge_a_q <= 1'b1;
            ge_b_q <= 1'b1;
            err_q  <= 1'b0;
        end else if (run) begin
            ge_a_q <= ge_a_d;
            ge_b_q <= ge_b_d;
            if (last) begin
                err_q <= ge_a_d | ge_b_d;
            end
        end else if (retire) begin
            err_q <= 1'b0;
        end
    end

    assign out_err = err_q;
`endif

endmodule

// File: tb/tb_mod_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_mod_addsub_serial
// Three instances: defaults (256/64), 256-bit with 32-bit limbs, and
// 64-bit with 32-bit limbs over 2^64-59. Directed tables, hand-written
// backpressure/reset sequences and random operands against a modular
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mod_addsub_serial;

    localparam logic [255:0] P   =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [63:0]  P64 = 64'hFFFFFFFF_FFFFFFC5;

    typedef struct {
        logic         op;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         tb_op;
    logic [255:0] tb_a;
    logic [255:0] tb_b;
    logic [2:0]   in_valid_v;
    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   out_ready_v;
    logic [255:0] r0;
    logic [255:0] r1;
    logic [63:0]  r2;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    logic [2:0]   out_err_v;
`endif

    mod_addsub_serial dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_op(tb_op),
        .in_a(tb_a), .in_b(tb_b),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_r(r0)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        , .out_err(out_err_v[0])
`endif
    );

    mod_addsub_serial #(.WIDTH(256), .LIMB(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_op(tb_op),
        .in_a(tb_a), .in_b(tb_b),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_r(r1)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        , .out_err(out_err_v[1])
`endif
    );

    mod_addsub_serial #(.WIDTH(64), .LIMB(32), .MODULUS(P64)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_op(tb_op),
        .in_a(tb_a[63:0]), .in_b(tb_b[63:0]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_r(r2)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        , .out_err(out_err_v[2])
`endif
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [255:0] exp_q[$];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] get_r(input int inst);
        case (inst)
            0:       return r0;
            1:       return r1;
            default: return {192'd0, r2};
        endcase
    endfunction

    function automatic logic get_err(input int inst);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        return out_err_v[inst];
`else
        return (inst < 0);
`endif
    endfunction

    function automatic logic [255:0] mod_of(input int inst);
        return (inst == 2) ? {192'd0, P64} : P;
    endfunction

    // Reference: plain modular arithmetic on wide integers.
    function automatic logic [255:0] model(input logic op, input logic [255:0] a,
                                           input logic [255:0] b,
                                           input logic [255:0] p);
        logic [257:0] t;
        if (op) begin
            t = ({2'b00, a} + {2'b00, b}) % {2'b00, p};
        end else begin
            t = ({2'b00, a} + {2'b00, p} - {2'b00, b}) % {2'b00, p};
        end
        return t[255:0];
    endfunction

    function automatic logic [255:0] rnd_below(input logic [255:0] p, input int inst);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v = {v[223:0], 32'($urandom)};
        end
        if (inst == 2) begin
            v = {192'd0, v[63:0]};
        end
        // Any value below 2^W is below 2p here, so one subtraction suffices.
        if (v >= p) begin
            v = v - p;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    // Drives one op into instance inst, waits (bounded) for the result,
    // returns it with the cycle count from acceptance edge, then retires it.
    task automatic do_op(input int inst, input logic op, input logic [255:0] a,
                         input logic [255:0] b, output logic [255:0] r,
                         output int lat, output logic err);
        tb_op = op;
        tb_a  = a;
        tb_b  = b;
        in_valid_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[inst] = 1'b0;
        lat = 0;
        while (!out_valid_v[inst] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40) begin
            check("result_timeout", 256'(out_valid_v[inst]), 256'd1);
        end
        r   = get_r(inst);
        err = get_err(inst);
        out_ready_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[inst] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[6];
    vec_t vecs64[4];
    int   lat_exp[3];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [255:0] r;
        logic [255:0] a;
        logic [255:0] b;
        logic         op;
        logic         err;
        logic         seen;
        int           lat;

        vecs[0]   = '{1'b0, 256'd0, 256'd1, P - 256'd1};
        vecs[1]   = '{1'b1, P - 256'd1, P - 256'd1, P - 256'd2};
        vecs[2]   = '{1'b1, P - 256'd1, 256'd1, 256'd0};
        vecs[3]   = '{1'b1, 256'h1234, 256'h0567, 256'h179B};
        vecs[4]   = '{1'b0, P - 256'd10, P - 256'd20, 256'hA};
        vecs[5]   = '{1'b0, 256'h1234, 256'h0567, 256'hCCD};
        vecs64[0] = '{1'b0, 256'd0, 256'd1, {192'd0, P64 - 64'd1}};
        vecs64[1] = '{1'b1, {192'd0, P64 - 64'd1}, {192'd0, P64 - 64'd1},
                      {192'd0, P64 - 64'd2}};
        vecs64[2] = '{1'b1, {192'd0, P64 - 64'd1}, 256'd1, 256'd0};
        vecs64[3] = '{1'b0, 256'h1234, 256'h0567, 256'hCCD};
        lat_exp   = '{4, 8, 2};

        rst_n       = 1'b0;
        tb_op       = 1'b0;
        tb_a        = '0;
        tb_b        = '0;
        in_valid_v  = '0;
        out_ready_v = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_in_ready_%0d", i), 256'(in_ready_v[i]), 256'd1);
            check($sformatf("reset_out_valid_%0d", i), 256'(out_valid_v[i]), 256'd0);
            check($sformatf("reset_out_r_%0d", i), get_r(i), 256'd0);
`ifdef MOD_ADDSUB_RANGE_CHK_EN
            check($sformatf("reset_out_err_%0d", i), 256'(out_err_v[i]), 256'd0);
`endif
        end

        // Directed table on both 256-bit instances
        for (int inst = 0; inst < 2; inst++) begin
            for (int k = 0; k < 6; k++) begin
                do_op(inst, vecs[k].op, vecs[k].a, vecs[k].b, r, lat, err);
                check($sformatf("vec%0d_inst%0d", k, inst), r, vecs[k].exp);
                check($sformatf("lat_vec%0d_inst%0d", k, inst), 256'(lat),
                      256'(lat_exp[inst]));
            end
        end

        // Directed table on the 64-bit instance
        for (int k = 0; k < 4; k++) begin
            do_op(2, vecs64[k].op, vecs64[k].a, vecs64[k].b, r, lat, err);
            check($sformatf("vec64_%0d", k), r, vecs64[k].exp);
            check($sformatf("lat64_%0d", k), 256'(lat), 256'(lat_exp[2]));
        end

        // Backpressure: hold DONE for 5 cycles while pulsing in_valid
        tb_op = 1'b1;
        tb_a  = 256'h1234;
        tb_b  = 256'h0567;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (!out_valid_v[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_valid", 256'(out_valid_v[0]), 256'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid_v[0] = k[0];
            tb_op = 1'b0;
            tb_a  = rnd_below(P, 0);
            tb_b  = rnd_below(P, 0);
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid_%0d", k), 256'(out_valid_v[0]), 256'd1);
            check($sformatf("bp_hold_r_%0d", k), r0, 256'h179B);
            check($sformatf("bp_in_ready_%0d", k), 256'(in_ready_v[0]), 256'd0);
        end
        // Retire with in_valid also high: must not be accepted on that edge.
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b0;
        check("bp_retired", 256'(out_valid_v[0]), 256'd0);
        check("bp_ready_after", 256'(in_ready_v[0]), 256'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid_v[0];
        end
        check("bp_no_phantom_op", 256'(seen), 256'd0);

        // Reset during the second RUN cycle
        tb_op = 1'b0;
        tb_a  = 256'd5;
        tb_b  = 256'd3;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_run_in_ready", 256'(in_ready_v[0]), 256'd1);
        check("rst_run_out_valid", 256'(out_valid_v[0]), 256'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid_v[0];
        end
        check("rst_run_no_result", 256'(seen), 256'd0);
        do_op(0, 1'b0, 256'd1, 256'd2, r, lat, err);
        check("rst_then_sub", r, P - 256'd1);

`ifdef MOD_ADDSUB_RANGE_CHK_EN
        do_op(0, 1'b1, P, 256'd0, r, lat, err);
        check("range_a_eq_p", 256'(err), 256'd1);
        do_op(0, 1'b0, 256'd0, P, r, lat, err);
        check("range_b_eq_p", 256'(err), 256'd1);
        do_op(0, 1'b1, P - 256'd1, 256'd0, r, lat, err);
        check("range_a_ok", 256'(err), 256'd0);
        do_op(2, 1'b1, {192'd0, P64}, 256'd0, r, lat, err);
        check("range64_a_eq_p", 256'(err), 256'd1);
`endif

        // Random operands against the reference model
        for (int inst = 0; inst < 3; inst++) begin
            for (int k = 0; k < 30; k++) begin
                op = 1'($urandom_range(0, 1));
                a  = rnd_below(mod_of(inst), inst);
                b  = rnd_below(mod_of(inst), inst);
                if (k == 0) begin
                    a = '0;
                    b = '0;
                end
                exp_q.push_back(model(op, a, b, mod_of(inst)));
                do_op(inst, op, a, b, r, lat, err);
                check($sformatf("rand_inst%0d_%0d_op%0d", inst, k, op), r,
                      exp_q.pop_front());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mod_addsub_serial.md
# mod_addsub_serial

Limb-serial modular adder/subtractor for the ECDSA datapath: computes (A + B) mod P or (A − B) mod P over a WIDTH-bit operand, LIMB bits per clock, behind valid/ready handshakes. It is the sequential, parametrised successor to the combinational mod_sub: it adds an add mode, generic width and modulus, and area-for-latency trade via LIMB. It sits between the point-arithmetic controller and the register file.

## Interface
- WIDTH, 256, operand/result width in bits
- LIMB, 64, bits processed per cycle; WIDTH % LIMB == 0 required (elaboration error otherwise)
- MODULUS, secp256k1 p (FFFF…FFFE FFFFFC2F), prime modulus, must be < 2^WIDTH
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept (high only in IDLE)
- in_op  in  1  0 = subtract, 1 = add
- in_a  in  WIDTH  operand A, precondition A < MODULUS
- in_b  in  WIDTH  operand B, precondition B < MODULUS
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_r  out  WIDTH  result, always in [0, MODULUS)
- out_err  out  1  only with MOD_ADDSUB_RANGE_CHK_EN (see Configuration)

## Operation
- NLIMB = WIDTH/LIMB. FSM states IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch in_a, in_b, in_op; limb counter=0; clear both carry flops; go RUN.
- RUN: each cycle processes limb i (LSB first) on two chains in parallel:
  - sub: chain D = A − B (borrow bd); chain T = D + P (carry).
  - add: chain S = A + B (carry cs); chain T = S − P (borrow bt).
  - Limb outputs shift into D/S and T registers; counter increments. After limb NLIMB−1, select and go DONE.
- Select: sub → R = T if final bd = 1, else D. Add → R = T if cs = 1 or bt = 0, else S. All arithmetic mod 2^WIDTH on T.
- DONE: out_valid=1, out_r stable. On out_ready: go IDLE. in_valid ignored outside IDLE.
- Inputs are sampled only at acceptance; changes during RUN/DONE have no effect.

## Timing
- Reset (rst_n low at an edge): state IDLE, in_ready=1, out_valid=0, out_r=0, out_err=0, counter and carries 0. Reset mid-RUN or mid-DONE aborts; no out_valid is produced for the aborted op.
- Acceptance edge E0 (in_valid & in_ready). Limbs processed on edges E1..ENLIMB; out_valid high in the cycle following ENLIMB: latency NLIMB cycles from acceptance edge (4 for defaults).
- out_valid held with out_r stable until out_ready sampled high; the op retires on that edge, in_ready high next cycle.
- Max throughput one op per NLIMB+2 cycles with out_ready tied high.
- Simultaneous in_valid and out_ready in DONE: input not accepted (in_ready=0).

## Configuration
- MOD_ADDSUB_RANGE_CHK_EN defined: out_err port present; at acceptance, A ≥ MODULUS or B ≥ MODULUS (compared serially alongside RUN) sets out_err, valid with out_valid and held until retirement; out_r still computed but undefined for the caller.
- Not defined: no out_err port, no comparators; out-of-range inputs give unspecified out_r.

## Structure
- Shared package ecc_pkg: SECP256K1_P constant, op encoding (OP_SUB=0, OP_ADD=1), FSM state enum.
- One sub-module limb_addsub: LIMB-bit add or subtract with carry/borrow in and out; instantiated twice (main chain, correction chain).

## Test plan
- Sub 0 − 1, defaults -> out_r = p−1, out_valid exactly 4 cycles after acceptance edge.
- Add (p−1) + (p−1) -> p−2 (carry-out path); add (p−1) + 1 -> 0; add 0x1234 + 0x0567 -> 0x179B.
- Sub (p−10) − (p−20) -> 0xA; sub 0x1234 − 0x0567 -> 0xCCD; repeat with LIMB=32, WIDTH=256 and WIDTH=64 with MODULUS=2^64−59.
- Backpressure: out_ready low 5 cycles in DONE -> out_r stable, in_ready=0, in_valid pulses ignored; retires on first out_ready.
- Reset asserted on second RUN cycle -> next cycle IDLE, in_ready=1, out_valid never asserts; following op 1 − 2 -> p−1.
- With MOD_ADDSUB_RANGE_CHK_EN: A = p, B = 0 -> out_err=1; A = p−1, B = 0 -> out_err=0.
